// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
// des_pkg: DES permutation tables, S-boxes, key shift schedule, FSM encodings.
// Rev 1.0
// ============================================================================
package des_pkg;

    localparam int ROUNDS = 16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Tables list DES bit numbers, bit 1 being the MSB of the source word.
    localparam int IP_TBL [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int IP_INV_TBL [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

    localparam int E_TBL [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_TBL [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Encryption left-shift amounts per round; decryption walks it backwards.
    localparam logic [1:0] SHIFT_TBL [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

    // Row-major: index = row*16 + col, row = {b1,b6}, col = b2..b5.
    localparam logic [3:0] SBOX [8][64] = '{
        '{4'd14, 4'd4, 4'd13, 4'd1, 4'd2, 4'd15, 4'd11, 4'd8, 4'd3, 4'd10, 4'd6, 4'd12, 4'd5, 4'd9, 4'd0, 4'd7,
          4'd0, 4'd15, 4'd7, 4'd4, 4'd14, 4'd2, 4'd13, 4'd1, 4'd10, 4'd6, 4'd12, 4'd11, 4'd9, 4'd5, 4'd3, 4'd8,
          4'd4, 4'd1, 4'd14, 4'd8, 4'd13, 4'd6, 4'd2, 4'd11, 4'd15, 4'd12, 4'd9, 4'd7, 4'd3, 4'd10, 4'd5, 4'd0,
          4'd15, 4'd12, 4'd8, 4'd2, 4'd4, 4'd9, 4'd1, 4'd7, 4'd5, 4'd11, 4'd3, 4'd14, 4'd10, 4'd0, 4'd6, 4'd13},
        '{4'd15, 4'd1, 4'd8, 4'd14, 4'd6, 4'd11, 4'd3, 4'd4, 4'd9, 4'd7, 4'd2, 4'd13, 4'd12, 4'd0, 4'd5, 4'd10,
          4'd3, 4'd13, 4'd4, 4'd7, 4'd15, 4'd2, 4'd8, 4'd14, 4'd12, 4'd0, 4'd1, 4'd10, 4'd6, 4'd9, 4'd11, 4'd5,
          4'd0, 4'd14, 4'd7, 4'd11, 4'd10, 4'd4, 4'd13, 4'd1, 4'd5, 4'd8, 4'd12, 4'd6, 4'd9, 4'd3, 4'd2, 4'd15,
          4'd13, 4'd8, 4'd10, 4'd1, 4'd3, 4'd15, 4'd4, 4'd2, 4'd11, 4'd6, 4'd7, 4'd12, 4'd0, 4'd5, 4'd14, 4'd9},
        '{4'd10, 4'd0, 4'd9, 4'd14, 4'd6, 4'd3, 4'd15, 4'd5, 4'd1, 4'd13, 4'd12, 4'd7, 4'd11, 4'd4, 4'd2, 4'd8,
          4'd13, 4'd7, 4'd0, 4'd9, 4'd3, 4'd4, 4'd6, 4'd10, 4'd2, 4'd8, 4'd5, 4'd14, 4'd12, 4'd11, 4'd15, 4'd1,
          4'd13, 4'd6, 4'd4, 4'd9, 4'd8, 4'd15, 4'd3, 4'd0, 4'd11, 4'd1, 4'd2, 4'd12, 4'd5, 4'd10, 4'd14, 4'd7,
          4'd1, 4'd10, 4'd13, 4'd0, 4'd6, 4'd9, 4'd8, 4'd7, 4'd4, 4'd15, 4'd14, 4'd3, 4'd11, 4'd5, 4'd2, 4'd12},
        '{4'd7, 4'd13, 4'd14, 4'd3, 4'd0, 4'd6, 4'd9, 4'd10, 4'd1, 4'd2, 4'd8, 4'd5, 4'd11, 4'd12, 4'd4, 4'd15,
          4'd13, 4'd8, 4'd11, 4'd5, 4'd6, 4'd15, 4'd0, 4'd3, 4'd4, 4'd7, 4'd2, 4'd12, 4'd1, 4'd10, 4'd14, 4'd9,
          4'd10, 4'd6, 4'd9, 4'd0, 4'd12, 4'd11, 4'd7, 4'd13, 4'd15, 4'd1, 4'd3, 4'd14, 4'd5, 4'd2, 4'd8, 4'd4,
          4'd3, 4'd15, 4'd0, 4'd6, 4'd10, 4'd1, 4'd13, 4'd8, 4'd9, 4'd4, 4'd5, 4'd11, 4'd12, 4'd7, 4'd2, 4'd14},
        '{4'd2, 4'd12, 4'd4, 4'd1, 4'd7, 4'd10, 4'd11, 4'd6, 4'd8, 4'd5, 4'd3, 4'd15, 4'd13, 4'd0, 4'd14, 4'd9,
          4'd14, 4'd11, 4'd2, 4'd12, 4'd4, 4'd7, 4'd13, 4'd1, 4'd5, 4'd0, 4'd15, 4'd10, 4'd3, 4'd9, 4'd8, 4'd6,
          4'd4, 4'd2, 4'd1, 4'd11, 4'd10, 4'd13, 4'd7, 4'd8, 4'd15, 4'd9, 4'd12, 4'd5, 4'd6, 4'd3, 4'd0, 4'd14,
          4'd11, 4'd8, 4'd12, 4'd7, 4'd1, 4'd14, 4'd2, 4'd13, 4'd6, 4'd15, 4'd0, 4'd9, 4'd10, 4'd4, 4'd5, 4'd3},
        '{4'd12, 4'd1, 4'd10, 4'd15, 4'd9, 4'd2, 4'd6, 4'd8, 4'd0, 4'd13, 4'd3, 4'd4, 4'd14, 4'd7, 4'd5, 4'd11,
          4'd10, 4'd15, 4'd4, 4'd2, 4'd7, 4'd12, 4'd9, 4'd5, 4'd6, 4'd1, 4'd13, 4'd14, 4'd0, 4'd11, 4'd3, 4'd8,
          4'd9, 4'd14, 4'd15, 4'd5, 4'd2, 4'd8, 4'd12, 4'd3, 4'd7, 4'd0, 4'd4, 4'd10, 4'd1, 4'd13, 4'd11, 4'd6,
          4'd4, 4'd3, 4'd2, 4'd12, 4'd9, 4'd5, 4'd15, 4'd10, 4'd11, 4'd14, 4'd1, 4'd7, 4'd6, 4'd0, 4'd8, 4'd13},
        '{4'd4, 4'd11, 4'd2, 4'd14, 4'd15, 4'd0, 4'd8, 4'd13, 4'd3, 4'd12, 4'd9, 4'd7, 4'd5, 4'd10, 4'd6, 4'd1,
          4'd13, 4'd0, 4'd11, 4'd7, 4'd4, 4'd9, 4'd1, 4'd10, 4'd14, 4'd3, 4'd5, 4'd12, 4'd2, 4'd15, 4'd8, 4'd6,
          4'd1, 4'd4, 4'd11, 4'd13, 4'd12, 4'd3, 4'd7, 4'd14, 4'd10, 4'd15, 4'd6, 4'd8, 4'd0, 4'd5, 4'd9, 4'd2,
          4'd6, 4'd11, 4'd13, 4'd8, 4'd1, 4'd4, 4'd10, 4'd7, 4'd9, 4'd5, 4'd0, 4'd15, 4'd14, 4'd2, 4'd3, 4'd12},
        '{4'd13, 4'd2, 4'd8, 4'd4, 4'd6, 4'd15, 4'd11, 4'd1, 4'd10, 4'd9, 4'd3, 4'd14, 4'd5, 4'd0, 4'd12, 4'd7,
          4'd1, 4'd15, 4'd13, 4'd8, 4'd10, 4'd3, 4'd7, 4'd4, 4'd12, 4'd5, 4'd6, 4'd11, 4'd0, 4'd14, 4'd9, 4'd2,
          4'd7, 4'd11, 4'd4, 4'd1, 4'd9, 4'd12, 4'd14, 4'd2, 4'd0, 4'd6, 4'd10, 4'd13, 4'd15, 4'd3, 4'd5, 4'd8,
          4'd2, 4'd1, 4'd14, 4'd7, 4'd4, 4'd10, 4'd8, 4'd13, 4'd15, 4'd12, 4'd9, 4'd0, 4'd3, 4'd5, 4'd6, 4'd11}};

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] res;
        logic [5:0]  pos;
        res = '0;
        for (int i = 0; i < 64; i++) begin
            pos = 6'(64 - IP_TBL[i]);
            res = {res[62:0], x[pos]};
        end
        return res;
    endfunction

    function automatic logic [63:0] perm_ip_inv(input logic [63:0] x);
        logic [63:0] res;
        logic [5:0]  pos;
        res = '0;
        for (int i = 0; i < 64; i++) begin
            pos = 6'(64 - IP_INV_TBL[i]);
            res = {res[62:0], x[pos]};
        end
        return res;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] res;
        logic [5:0]  pos;
        res = '0;
        for (int i = 0; i < 56; i++) begin
            pos = 6'(64 - PC1_TBL[i]);
            res = {res[54:0], x[pos]};
        end
        return res;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] res;
        logic [5:0]  pos;
        res = '0;
        for (int i = 0; i < 48; i++) begin
            pos = 6'(56 - PC2_TBL[i]);
            res = {res[46:0], x[pos]};
        end
        return res;
    endfunction

    function automatic logic [47:0] perm_e(input logic [31:0] x);
        logic [47:0] res;
        logic [4:0]  pos;
        res = '0;
        for (int i = 0; i < 48; i++) begin
            pos = 5'(32 - E_TBL[i]);
            res = {res[46:0], x[pos]};
        end
        return res;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] x);
        logic [31:0] res;
        logic [4:0]  pos;
        res = '0;
        for (int i = 0; i < 32; i++) begin
            pos = 5'(32 - P_TBL[i]);
            res = {res[30:0], x[pos]};
        end
        return res;
    endfunction

    // Right-rotate amount before decryption round rnd (1..16).
    function automatic logic [1:0] dec_rot_amt(input logic [4:0] rnd);
        logic [1:0] amt;
        amt = 2'd0;
        if (rnd >= 5'd2 && rnd <= 5'd16) begin
            amt = SHIFT_TBL[4'(5'd17 - rnd)];
        end
        return amt;
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] v, input logic [1:0] n);
        logic [27:0] res;
        case (n)
            2'd1:    res = {v[0], v[27:1]};
            2'd2:    res = {v[1:0], v[27:2]};
            default: res = v;
        endcase
        return res;
    endfunction

    // DES keys carry odd parity in every byte.
    function automatic logic key_parity_ok(input logic [63:0] k);
        return (^k[63:56]) & (^k[55:48]) & (^k[47:40]) & (^k[39:32]) &
               (^k[31:24]) & (^k[23:16]) & (^k[15:8])  & (^k[7:0]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/des_f_func.sv
`default_nettype none
// ============================================================================
// des_f_func: combinational DES round function f(R, K) = P(S(E(R) ^ K)).
// Rev 1.0
// ============================================================================
module des_f_func
    import des_pkg::*;
(
    input  logic [31:0] r,
    input  logic [47:0] k,
    output logic [31:0] f
);

    logic [47:0] mixed;
    logic [31:0] s_out;

    assign mixed = perm_e(r) ^ k;

    for (genvar j = 0; j < 8; j++) begin : g_sbox
        logic [5:0] six;
        assign six = mixed[47 - 6*j -: 6];
        assign s_out[31 - 4*j -: 4] = SBOX[j][{six[5], six[0], six[4:1]}];
    end

    assign f = perm_p(s_out);

endmodule
`default_nettype wire

// File: rtl/des_decrypt_core.sv
`default_nettype none
// ============================================================================
// des_decrypt_core: iterative single-DES decryptor, one Feistel round per clock.
// Build option DES_DEC_PARITY_CHK_EN adds key parity rejection. Rev 1.0
// ============================================================================
module des_decrypt_core
    import des_pkg::*;
#(
    parameter int HOLD_OUTPUT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] cipher_text,
    input  logic [63:0] key_din,
    output logic [63:0] plain_text,
    output logic        dat_valid,
    output logic        busy
`ifdef DES_DEC_PARITY_CHK_EN
    ,
    output logic        key_parity_err
`endif
);

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] l_half;
    logic [31:0] r_half;
    logic [27:0] c_half;
    logic [27:0] d_half;
    logic [63:0] pt_q;
    logic        valid_q;

    logic [1:0]  rot_amt;
    logic [27:0] c_rot;
    logic [27:0] d_rot;
    logic [47:0] round_key;
    logic [31:0] f_out;
    logic [63:0] ip_blk;
    logic [55:0] pc1_key;
    logic        start_window;
    logic        key_ok;
    logic        accept;

    // K16 first: C/D start at PC1 and rotate right before every later round.
    assign rot_amt   = dec_rot_amt(cnt);
    assign c_rot     = rotr28(c_half, rot_amt);
    assign d_rot     = rotr28(d_half, rot_amt);
    assign round_key = perm_pc2({c_rot, d_rot});
    assign ip_blk    = perm_ip(cipher_text);
    assign pc1_key   = perm_pc1(key_din);

    des_f_func u_f_func (
        .r (r_half),
        .k (round_key),
        .f (f_out)
    );

`ifdef DES_DEC_PARITY_CHK_EN
    assign key_ok = key_parity_ok(key_din);
`else
    assign key_ok = 1'b1;
`endif

    assign start_window = (state == S_IDLE) || (state == S_DONE);
    assign accept       = start && start_window && key_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            l_half  <= '0;
            r_half  <= '0;
            c_half  <= '0;
            d_half  <= '0;
            pt_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (state == S_ROUND) begin
                if (cnt >= 5'd1 && cnt <= 5'(ROUNDS)) begin
                    l_half <= r_half;
                    r_half <= l_half ^ f_out;
                    c_half <= c_rot;
                    d_half <= d_rot;
                    if (cnt == 5'(ROUNDS)) begin
                        state <= S_DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end else begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            end else begin
                // Final swap folds into the {R16, L16} ordering fed to IP^-1.
                if (state == S_DONE) begin
                    pt_q    <= perm_ip_inv({r_half, l_half});
                    valid_q <= 1'b1;
                end
                state <= S_IDLE;
                cnt   <= '0;
                if (accept) begin
                    state  <= S_ROUND;
                    cnt    <= 5'd1;
                    l_half <= ip_blk[63:32];
                    r_half <= ip_blk[31:0];
                    c_half <= pc1_key[55:28];
                    d_half <= pc1_key[27:0];
                end
            end
        end
    end

`ifdef DES_DEC_PARITY_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_parity_err <= 1'b0;
        end else begin
            key_parity_err <= start && start_window && !key_ok;
        end
    end
`endif

    assign dat_valid = valid_q;
    assign busy      = (state == S_ROUND);

    if (HOLD_OUTPUT != 0) begin : g_hold_out
        assign plain_text = pt_q;
    end else begin : g_gated_out
        assign plain_text = valid_q ? pt_q : 64'd0;
    end

endmodule
`default_nettype wire
